adder_slice_scheduler: RTL and testbench
========================================

// Module: adder_slice_scheduler
// PURPOSE
//  Front-end controller for the bit-slice parallel adder (M operands x N bits, one slice per clk).
//  Accepts M operand words over a valid/ready stream into a local buffer.
//  Clears the adder, then issues N bit-slices LSB-first, one per cycle, and waits for adder done.
//  Captures the sum and returns it over a valid/ready result port. One job in flight at a time.
// PARAMETERS
//  M        32   operands per job; slice width
//  N        32   operand width; number of slices issued per job
//  RES_W    37   adder result width (N + clog2(M))
//  TIMEOUT  64   WAIT-state watchdog limit in cycles (ADDER_TIMEOUT_EN builds only)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operand word valid
//  in_ready     out  1      operand word accepted when in_valid & in_ready
//  in_data      in   N      operand word
//  in_last      in   1      final word of job; rows not yet written are zero
//  res_valid    out  1      result valid; held until res_ready
//  res_ready    in   1      result consumer ready
//  res_data     out  RES_W  sum of all operands of the job
//  adder_clr    out  1      one-cycle synchronous clear to adder, active-high
//  slice_data   out  M      bit k of every buffered word, row r -> slice_data[r]
//  adder_rdy    in   1      adder done strobe
//  adder_result in   RES_W  adder accumulator
//  busy         out  1      high in any state except IDLE
//  err          out  1      sticky timeout flag (ADDER_TIMEOUT_EN builds only; else tied 0)
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; in_ready=0, res_valid=0, res_data=0, adder_clr=0,
//   slice_data=0, busy=0, err=0; word and slice counters=0; buffer cleared.
//  FSM: IDLE -> LOAD -> CLEAR -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: buffer zeroed; in_ready=1; the first accepted word is written to row 0 -> LOAD.
//  LOAD: in_ready=1; row w <= in_data on each handshake; w increments.
//   Leaves to CLEAR on a handshake with in_last=1, or on the M-th word (w==M-1).
//   A word arriving with w==M-1 and in_last=0 still ends the job; no wrap, no overwrite.
//  CLEAR: in_ready=0; adder_clr=1 for exactly one cycle -> ISSUE, k=0.
//  ISSUE: slice_data = column k, for N consecutive cycles, k = 0..N-1 -> WAIT.
//   slice_data=0 in all other states.
//  WAIT: slice_data=0; on the first cycle with adder_rdy=1, res_data <= adder_result -> DONE.
//   adder_rdy seen in any state except WAIT is ignored.
//  DONE: res_valid=1, res_data stable until res_valid&res_ready -> IDLE (res_valid=0 next cycle).
//  Latency: last input handshake -> first slice = 2 cycles; the job takes N slice cycles,
//   then the adder's own done latency.
//  rst_n asserted mid-job: job is discarded, no res_valid, and the next job starts clean.
//  in_valid while not in IDLE/LOAD: in_ready=0, so there is no handshake and no side effect.
//  Arithmetic: the scheduler does no arithmetic; res_data is adder_result verbatim (RES_W bits).
// CONFIGURATION
//  ADDER_TIMEOUT_EN defined:
//   - A cycle counter runs in WAIT.
//   - If adder_rdy is still 0 after TIMEOUT cycles: err<=1 (sticky until reset), res_data<=0,
//     and the FSM goes to DONE, so the consumer still sees one result.
//  ADDER_TIMEOUT_EN undefined: no counter; WAIT holds until adder_rdy; err tied 0.
// STRUCTURE
//  Package adder_sched_pkg:
//   - state encoding localparams S_IDLE..S_DONE
//   - default M/N/RES_W
//   - clog2 helper for counter widths
//  Sub-module slice_buffer: M x N register array, row write port (addr, data, we),
//   synchronous clear, combinational column read (k -> M bits).
//  Top holds the FSM, the counters, the result register and the watchdog.
// TESTING
//  1) Full job: 32 words all 0xFFFFFFFF, model adder -> slices all-ones for 32 cycles;
//     res_data=32*(2^32-1)=0x1FFFFFFFE0.
//  2) Short job: words 5,7,9 with in_last on the 3rd -> rows 3..31 zero;
//     res_data=21; slice k=0 = 32'h7.
//  3) Backpressure: res_ready=0 for 10 cycles -> res_valid and res_data held;
//     in_ready=0 throughout; handshake -> IDLE.
//  4) Overflow guard: 33 words, in_last never set -> job closes after the 32nd word;
//     the 33rd word is not accepted until IDLE.
//  5) Reset mid-ISSUE at k=10 -> all outputs at reset values; next job 1,2 -> res_data=3.
//  6) ADDER_TIMEOUT_EN, adder_rdy held 0 -> err=1 and res_valid after TIMEOUT WAIT cycles,
//     res_data=0.

Source files
------------

// File: rtl/adder_slice_scheduler_pkg.sv
// Shared definitions for the bit-slice adder front-end.
//   - default geometry (M operands x N bits, RES_W result bits, TIMEOUT cycles)
//   - FSM state type
//   - clog2 helper for counter widths
package adder_sched_pkg;

  localparam int unsigned DEF_M       = 32;
  localparam int unsigned DEF_N       = 32;
  localparam int unsigned DEF_RES_W   = 37;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Minimum 1 bit so a counter for a value of 1 still has a legal width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder_slice_scheduler_if.sv
// Operand input stream and result output stream of adder_slice_scheduler.
//   in_valid/in_ready/in_data/in_last : operand words, producer -> scheduler
//   res_valid/res_ready/res_data      : job sum, scheduler -> consumer
// Modports: master = producer/consumer side, slave = scheduler side.
interface adder_slice_scheduler_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned RES_W = 37
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/adder_slice_scheduler_slice_buffer.sv
// M x N operand buffer for the slice scheduler.
//   clk, rst_n : clock, async active-low reset (clears all rows)
//   i_clr      : synchronous clear of all rows (wins over i_we)
//   i_we/i_addr/i_data : row write port
//   i_col/o_col: combinational column read, o_col[r] = row r bit i_col
module slice_buffer
  import adder_sched_pkg::*;
#(
  parameter int unsigned M = DEF_M,
  parameter int unsigned N = DEF_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [clog2(M)-1:0]   i_addr,
  input  logic [N-1:0]          i_data,
  input  logic [clog2(N)-1:0]   i_col,
  output logic [M-1:0]          o_col
);

  logic [N-1:0] r_mem [M];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < M; r++) r_mem[r] <= '0;
    end else if (i_clr) begin
      for (int unsigned r = 0; r < M; r++) r_mem[r] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  always_comb begin
    o_col = '0;
    for (int unsigned r = 0; r < M; r++) o_col[r] = r_mem[r][i_col];
  end

endmodule

// File: rtl/adder_slice_scheduler.sv
// Front-end controller for the bit-slice parallel adder.
// Buffers up to M operand words, clears the adder, issues N bit-slices
// LSB-first (one per clock), waits for the adder done strobe and returns
// the captured sum over a valid/ready result port. One job at a time.
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : operand stream in, result stream out
//   adder_clr     : one-cycle clear to the adder
//   slice_data    : column k of the buffer during ISSUE, else 0
//   adder_rdy     : adder done strobe (only honoured in WAIT)
//   adder_result  : adder accumulator, captured verbatim
//   busy          : high outside IDLE
//   err           : sticky watchdog flag
// Build option: ADDER_TIMEOUT_EN enables the WAIT watchdog; otherwise err=0.
module adder_slice_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned M       = DEF_M,
  parameter int unsigned N       = DEF_N,
  parameter int unsigned RES_W   = DEF_RES_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_slice_scheduler_if.slave bus,
  output logic                  adder_clr,
  output logic [M-1:0]          slice_data,
  input  logic                  adder_rdy,
  input  logic [RES_W-1:0]      adder_result,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned WW = clog2(M);
  localparam int unsigned KW = clog2(N);

  state_t            r_state, w_state_n;
  logic [WW-1:0]     r_w;
  logic [KW-1:0]     r_k;
  logic [RES_W-1:0]  r_res;
  logic              w_accept, w_hs, w_we, w_clr;
  logic [WW-1:0]     w_addr;
  logic [M-1:0]      w_col;

  // Gated by rst_n so in_ready reads 0 while reset is held, even though
  // the IDLE state itself accepts words.
  assign w_accept     = rst_n && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_hs         = w_accept && bus.in_valid;
  assign bus.in_ready = w_accept;
  assign bus.res_data = r_res;

  slice_buffer #(.M(M), .N(N)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_we   (w_we),
    .i_addr (w_addr),
    .i_data (bus.in_data),
    .i_col  (r_k),
    .o_col  (w_col)
  );

`ifdef ADDER_TIMEOUT_EN
  localparam int unsigned TW = clog2(TIMEOUT);
  logic [TW-1:0] r_wd;
  logic          r_err;
  logic          w_tmo;
  assign w_tmo = (r_state == S_WAIT) && !adder_rdy && (r_wd == TW'(TIMEOUT - 1));
  assign err   = r_err;
`else
  logic w_tmo;
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    w_state_n     = r_state;
    bus.res_valid = 1'b0;
    adder_clr     = 1'b0;
    slice_data    = '0;
    busy          = 1'b1;
    w_we          = 1'b0;
    w_clr         = 1'b0;
    w_addr        = r_w;
    unique case (r_state)
      S_IDLE: begin
        busy   = 1'b0;
        w_addr = '0;
        if (w_hs) begin
          w_we      = 1'b1;
          w_state_n = (bus.in_last || (M == 1)) ? S_CLEAR : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          w_we = 1'b1;
          if (bus.in_last || (r_w == WW'(M - 1))) w_state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        adder_clr = 1'b1;
        w_state_n = S_ISSUE;
      end
      S_ISSUE: begin
        slice_data = w_col;
        if (r_k == KW'(N - 1)) w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (adder_rdy || w_tmo) w_state_n = S_DONE;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          w_clr     = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_k     <= '0;
      r_res   <= '0;
`ifdef ADDER_TIMEOUT_EN
      r_wd    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      case (r_state)
        S_IDLE:  if (w_hs) r_w <= WW'(1);
        S_LOAD:  if (w_hs) r_w <= r_w + WW'(1);
        S_CLEAR: begin
          r_w <= '0;
          r_k <= '0;
        end
        S_ISSUE: r_k <= r_k + KW'(1);
        S_WAIT: begin
          if (adder_rdy) r_res <= adder_result;
          else if (w_tmo) r_res <= '0;
        end
        default: ;
      endcase
`ifdef ADDER_TIMEOUT_EN
      if (r_state == S_WAIT && !adder_rdy && !w_tmo) r_wd <= r_wd + TW'(1);
      else r_wd <= '0;
      if (w_tmo) r_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_adder_slice_scheduler.sv
module tb_adder_slice_scheduler;

  localparam int unsigned M       = 32;
  localparam int unsigned N       = 32;
  localparam int unsigned RES_W   = 37;
  localparam int unsigned TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             adder_clr, adder_rdy, busy, err;
  logic [M-1:0]     slice_data;
  logic [RES_W-1:0] adder_result;

  adder_slice_scheduler_if #(.N(N), .RES_W(RES_W)) bus ();

  adder_slice_scheduler #(.M(M), .N(N), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .adder_clr    (adder_clr),
    .slice_data   (slice_data),
    .adder_rdy    (adder_rdy),
    .adder_result (adder_result),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Behavioural adder: after a clear, accumulates N slices weighted 2^k,
  // then strobes done after m_lat extra cycles (if adder_en).
  logic             adder_en = 1'b1;
  int               m_lat = 0;
  logic [RES_W-1:0] m_acc;
  int               m_cnt, m_dly;
  logic             m_active;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= '0; m_cnt <= 0; m_dly <= 0; m_active <= 1'b0;
      adder_rdy <= 1'b0; adder_result <= '0;
    end else begin
      adder_rdy <= 1'b0;
      if (adder_clr) begin
        m_acc <= '0; m_cnt <= 0; m_active <= 1'b1;
      end else if (m_active && m_cnt < int'(N)) begin
        m_acc <= m_acc + (RES_W'($countones(slice_data)) << m_cnt);
        m_cnt <= m_cnt + 1;
        m_dly <= m_lat;
      end else if (m_active) begin
        if (m_dly > 0) m_dly <= m_dly - 1;
        else if (adder_en) begin
          adder_rdy <= 1'b1; adder_result <= m_acc; m_active <= 1'b0;
        end
      end
    end
  end

  // Reference job and observations
  logic [N-1:0]     ref_words [M];
  int               nw;
  logic             obs_clr, obs_inr_busy, obs_got_res, obs_err;
  logic             obs_post_valid, obs_post_busy, obs_post_inr;
  logic [M-1:0]     obs_slice [N];
  logic [RES_W-1:0] obs_res;
  int               obs_wait;
  logic             bp_valid [10];
  logic             bp_inr [10];
  logic [RES_W-1:0] bp_data [10];

  function automatic logic [RES_W-1:0] ref_sum();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < nw; i++) s = s + 64'(ref_words[i]);
    return s[RES_W-1:0];
  endfunction

  function automatic logic [M-1:0] ref_col(input int k);
    logic [M-1:0] c;
    logic [N-1:0] w;
    c = '0;
    for (int r = 0; r < int'(M); r++) begin
      w = ref_words[r];
      c[r] = (r < nw) ? w[k] : 1'b0;
    end
    return c;
  endfunction

  // Drives one job and records what the DUT showed; tests do the comparing.
  task automatic do_job(input bit use_last, input int bp, input int abort_k, input bit hold33);
    int guard;
    obs_got_res = 1'b0; obs_inr_busy = 1'b0;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = ref_words[i];
      bus.in_last  = use_last && (i == nw - 1);
      guard = 0;
      while (!bus.in_ready && guard < 200) begin @(negedge clk); guard++; end
      if (!bus.in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL in_ready_timeout: word %0d never accepted, in_ready=%b required 1", i, bus.in_ready);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (hold33) bus.in_data = 32'hDEADBEEF;
    else bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    obs_clr      = adder_clr;
    obs_inr_busy = bus.in_ready;
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      obs_slice[k] = slice_data;
      obs_inr_busy |= bus.in_ready;
      if (k == abort_k) begin rst_n = 1'b0; return; end
    end
    obs_wait = 0;
    do begin
      @(negedge clk); obs_wait++;
      if (!bus.res_valid) obs_inr_busy |= bus.in_ready;
    end while (!bus.res_valid && obs_wait < 500);
    obs_got_res = bus.res_valid;
    obs_res     = bus.res_data;
    obs_err     = err;
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      bp_valid[j] = bus.res_valid; bp_data[j] = bus.res_data; bp_inr[j] = bus.in_ready;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready  = 1'b0;
    obs_post_valid = bus.res_valid;
    obs_post_busy  = busy;
    obs_post_inr   = bus.in_ready;
    bus.in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.res_data !== '0) begin n_fail++; $display("FAIL rst_res_data: got %h want 0", bus.res_data); end
    n_checks++; if (adder_clr !== 1'b0) begin n_fail++; $display("FAIL rst_adder_clr: got %b want 0", adder_clr); end
    n_checks++; if (slice_data !== '0) begin n_fail++; $display("FAIL rst_slice: got %h want 0", slice_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_full_job();
    nw = 32;
    for (int i = 0; i < nw; i++) ref_words[i] = 32'hFFFFFFFF;
    m_lat = 1;
    do_job(1'b1, 0, -1, 1'b0);
    n_checks++; if (obs_clr !== 1'b1) begin n_fail++; $display("FAIL full_clr: got %b want 1", obs_clr); end
    for (int k = 0; k < int'(N); k++) begin
      n_checks++;
      if (obs_slice[k] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL full_slice%0d: got %h want ffffffff", k, obs_slice[k]); end
    end
    n_checks++; if (obs_got_res !== 1'b1) begin n_fail++; $display("FAIL full_res_valid: got %b want 1", obs_got_res); end
    n_checks++; if (obs_res !== 37'h1FFFFFFFE0) begin n_fail++; $display("FAIL full_sum: got %h want 1fffffffe0", obs_res); end
    n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b want 0", obs_err); end
    n_checks++; if (obs_inr_busy !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_busy: got %b want 0", obs_inr_busy); end
    n_checks++; if (obs_post_valid !== 1'b0) begin n_fail++; $display("FAIL full_post_valid: got %b want 0", obs_post_valid); end
    n_checks++; if (obs_post_busy !== 1'b0) begin n_fail++; $display("FAIL full_post_busy: got %b want 0", obs_post_busy); end
    n_checks++; if (obs_post_inr !== 1'b1) begin n_fail++; $display("FAIL full_post_in_ready: got %b want 1", obs_post_inr); end
  endtask

  task automatic test_short_job();
    nw = 3;
    ref_words[0] = 32'd5; ref_words[1] = 32'd7; ref_words[2] = 32'd9;
    m_lat = 0;
    do_job(1'b1, 0, -1, 1'b0);
    n_checks++; if (obs_slice[0] !== 32'h7) begin n_fail++; $display("FAIL short_slice0: got %h want 7", obs_slice[0]); end
    for (int k = 1; k < int'(N); k++) begin
      n_checks++;
      if (obs_slice[k] !== ref_col(k)) begin n_fail++; $display("FAIL short_slice%0d: got %h want %h", k, obs_slice[k], ref_col(k)); end
    end
    n_checks++; if (obs_res !== 37'd21) begin n_fail++; $display("FAIL short_sum: got %0d want 21", obs_res); end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      nw = (j == 0) ? 1 : int'($urandom_range(1, M));
      for (int i = 0; i < int'(M); i++) ref_words[i] = $urandom;
      m_lat = int'($urandom_range(0, 3));
      do_job(1'b1, 0, -1, 1'b0);
      for (int k = 0; k < int'(N); k++) begin
        n_checks++;
        if (obs_slice[k] !== ref_col(k)) begin n_fail++; $display("FAIL rand%0d_slice%0d: got %h want %h", j, k, obs_slice[k], ref_col(k)); end
      end
      n_checks++;
      if (obs_res !== ref_sum()) begin n_fail++; $display("FAIL rand%0d_sum: got %h want %h", j, obs_res, ref_sum()); end
    end
  endtask

  task automatic test_backpressure();
    nw = 4;
    for (int i = 0; i < nw; i++) ref_words[i] = $urandom;
    m_lat = 2;
    do_job(1'b1, 10, -1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      n_checks++; if (bp_valid[j] !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", j, bp_valid[j]); end
      n_checks++; if (bp_data[j] !== ref_sum()) begin n_fail++; $display("FAIL bp_data%0d: got %h want %h", j, bp_data[j], ref_sum()); end
      n_checks++; if (bp_inr[j] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", j, bp_inr[j]); end
    end
    n_checks++; if (obs_post_valid !== 1'b0) begin n_fail++; $display("FAIL bp_post_valid: got %b want 0", obs_post_valid); end
    n_checks++; if (obs_post_inr !== 1'b1) begin n_fail++; $display("FAIL bp_post_in_ready: got %b want 1", obs_post_inr); end
  endtask

  task automatic test_overflow();
    nw = 32;
    for (int i = 0; i < nw; i++) ref_words[i] = $urandom;
    m_lat = 0;
    do_job(1'b0, 0, -1, 1'b1);
    n_checks++; if (obs_clr !== 1'b1) begin n_fail++; $display("FAIL ovf_clr: got %b want 1", obs_clr); end
    n_checks++; if (obs_inr_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_in_ready_busy: got %b want 0", obs_inr_busy); end
    n_checks++; if (obs_res !== ref_sum()) begin n_fail++; $display("FAIL ovf_sum: got %h want %h", obs_res, ref_sum()); end
    n_checks++; if (obs_slice[31] !== ref_col(31)) begin n_fail++; $display("FAIL ovf_slice31: got %h want %h", obs_slice[31], ref_col(31)); end
    n_checks++; if (obs_post_inr !== 1'b1) begin n_fail++; $display("FAIL ovf_idle_in_ready: got %b want 1", obs_post_inr); end
  endtask

  task automatic test_reset_mid_issue();
    nw = 5;
    for (int i = 0; i < nw; i++) ref_words[i] = $urandom;
    do_job(1'b1, 0, 10, 1'b0);
    n_checks++; if (obs_slice[10] !== ref_col(10)) begin n_fail++; $display("FAIL mid_slice10: got %h want %h", obs_slice[10], ref_col(10)); end
    #1;
    n_checks++; if (slice_data !== '0) begin n_fail++; $display("FAIL mid_rst_slice: got %h want 0", slice_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_res_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.res_data !== '0) begin n_fail++; $display("FAIL mid_rst_res_data: got %h want 0", bus.res_data); end
    @(negedge clk);
    rst_n = 1'b1;
    nw = 2;
    ref_words[0] = 32'd1; ref_words[1] = 32'd2;
    do_job(1'b1, 0, -1, 1'b0);
    n_checks++; if (obs_slice[0] !== 32'h1) begin n_fail++; $display("FAIL mid_next_slice0: got %h want 1", obs_slice[0]); end
    n_checks++; if (obs_slice[1] !== 32'h2) begin n_fail++; $display("FAIL mid_next_slice1: got %h want 2", obs_slice[1]); end
    n_checks++; if (obs_res !== 37'd3) begin n_fail++; $display("FAIL mid_next_sum: got %0d want 3", obs_res); end
  endtask

`ifdef ADDER_TIMEOUT_EN
  task automatic test_timeout();
    nw = 3;
    for (int i = 0; i < nw; i++) ref_words[i] = $urandom;
    adder_en = 1'b0;
    do_job(1'b1, 0, -1, 1'b0);
    adder_en = 1'b1;
    n_checks++; if (obs_got_res !== 1'b1) begin n_fail++; $display("FAIL tmo_res_valid: got %b want 1", obs_got_res); end
    n_checks++; if (obs_wait != int'(TIMEOUT) + 1) begin n_fail++; $display("FAIL tmo_cycles: got %0d want %0d", obs_wait, TIMEOUT + 1); end
    n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", obs_err); end
    n_checks++; if (obs_res !== '0) begin n_fail++; $display("FAIL tmo_res_data: got %h want 0", obs_res); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
    test_reset();
    test_full_job();
    test_short_job();
    test_random_jobs();
    test_backpressure();
    test_overflow();
    test_reset_mid_issue();
`ifdef ADDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, time=%0t limit=2000000", $time);
    $fatal(1, "global timeout");
  end

endmodule
